gate_exerciser: RTL and testbench

Synthesizable self-test controller for a 2-input combinational gate. It drives the gate's `A`/`B` inputs through all four input combinations and samples the gate's `Y` output after a programmable settle time. It compares each sample against a parameterized truth table and reports pass/fail, an error count and a per-vector failure map. It sits on the opposite side of the gate from its inputs: it generates the stimulus and checks the response in hardware, so it can run on-board as a BIST wrapper for gate modules such as the XNOR gate.

---
 rtl/gate_exerciser.sv | 107 ++++++++++
 tb/tb_gate_exerciser.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_exerciser.sv
// Built-in self-test controller for a 2-input gate: walks {A,B} through 00..11,
// samples Y after SETTLE extra cycles and checks it against a truth table.
module gate_exerciser #(
  parameter logic [3:0]  TRUTH  = 4'b1001,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_e;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [7:0] cnt_q;

  logic       mismatch;
  logic [1:0] idx_d;
  logic [2:0] err_d;

  always_comb begin
    mismatch = (y_in != TRUTH[idx_q]);
    idx_d    = idx_q + 2'd1;
    // err_d includes the compare made on the current edge, so pass sees it.
    err_d    = err_count + {2'b00, mismatch};
  end

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // the reset is synchronous, so it only lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          a_out <= 1'b0;
          b_out <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            state_q   <= S_DRIVE;
            idx_q     <= 2'd0;
            cnt_q     <= 8'd0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            busy      <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q != SETTLE_C) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            if (mismatch) begin
              fail_vec[idx_q] <= 1'b1;
              err_count       <= err_d;
            end
            if (idx_q != 2'd3) begin
              idx_q <= idx_d;
              cnt_q <= 8'd0;
              a_out <= idx_d[1];
              b_out <= idx_d[0];
            end else begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_d == 3'd0);
              a_out   <= 1'b0;
              b_out   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          a_out   <= 1'b0;
          b_out   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: three instances (SETTLE 2, 0, 1) share one gate model
// that is either combinational or registered with a selectable truth table.
module tb_gate_exerciser;

  localparam logic [3:0] TRUTH = 4'b1001;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [3:0] g_fn;
  logic reg_mode;

  always #5 clk = ~clk;

  logic       a_w    [3];
  logic       b_w    [3];
  logic       y_w    [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [2:0] err_w  [3];
  logic [3:0] fail_w [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int unsigned ST = (gi == 0) ? 2 : ((gi == 1) ? 0 : 1);
    logic y_q;
    always_ff @(posedge clk) y_q <= g_fn[{a_w[gi], b_w[gi]}];
    assign y_w[gi] = reg_mode ? y_q : g_fn[{a_w[gi], b_w[gi]}];

    gate_exerciser #(.TRUTH(TRUTH), .SETTLE(ST)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .y_in     (y_w[gi]),
      .a_out    (a_w[gi]),
      .b_out    (b_w[gi]),
      .busy     (busy_w[gi]),
      .done     (done_w[gi]),
      .pass     (pass_w[gi]),
      .err_count(err_w[gi]),
      .fail_vec (fail_w[gi])
    );
  end

  int st [3] = '{2, 0, 1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: for each vector, which gate input pair is Y reflecting at sample time.
  function automatic void model(input logic [3:0] g, input logic regm, input int s,
                                output logic [3:0] fv, output int ec, output logic ps);
    logic [3:0] t;
    int         src;
    t  = TRUTH;
    fv = 4'd0;
    ec = 0;
    for (int v = 0; v < 4; v++) begin
      // A registered gate with no settle time shows the previous vector (idle drives 00).
      src = (regm && s == 0) ? ((v == 0) ? 0 : v - 1) : v;
      if (g[src] != t[v]) begin
        fv[v] = 1'b1;
        ec++;
      end
    end
    ps = (ec == 0);
  endfunction

  int         busy_cyc [3];
  int         done_cnt [3];
  int         done_at  [3];
  logic       r_pass   [3];
  logic [2:0] r_err    [3];
  logic [3:0] r_fail   [3];
  logic [1:0] ab_log   [3][24];
  logic       busy_log [3][32];
  logic       done_log [3][32];

  task automatic do_run(input int ncyc);
    for (int i = 0; i < 3; i++) begin
      busy_cyc[i] = 0;
      done_cnt[i] = 0;
      done_at[i]  = -1;
      r_pass[i]   = 1'bx;
      r_err[i]    = 3'bx;
      r_fail[i]   = 4'bx;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) busy_cyc[i]++;
        if (done_w[i]) begin
          done_cnt[i]++;
          done_at[i] = c;
          r_pass[i]  = pass_w[i];
          r_err[i]   = err_w[i];
          r_fail[i]  = fail_w[i];
        end
        if (c < 24) ab_log[i][c] = {a_w[i], b_w[i]};
      end
      @(negedge clk);
    end
  endtask

  task automatic check_run(input string tag, input int i, input logic [3:0] ef,
                           input int ee, input logic ep);
    string n;
    n = $sformatf("%s/s%0d", tag, st[i]);
    check({n, " busy_cycles"}, 32'(busy_cyc[i]), 32'(4 * (st[i] + 1)));
    check({n, " done_count"},  32'(done_cnt[i]), 32'd1);
    check({n, " done_cycle"},  32'(done_at[i]),  32'(4 * (st[i] + 1)));
    check({n, " pass"},        32'(r_pass[i]),   32'(ep));
    check({n, " err_count"},   32'(r_err[i]),    32'(ee));
    check({n, " fail_vec"},    32'(r_fail[i]),   32'(ef));
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/s%0d a_out", tag, st[i]),     32'(a_w[i]),    32'd0);
      check($sformatf("%s/s%0d b_out", tag, st[i]),     32'(b_w[i]),    32'd0);
      check($sformatf("%s/s%0d busy", tag, st[i]),      32'(busy_w[i]), 32'd0);
      check($sformatf("%s/s%0d done", tag, st[i]),      32'(done_w[i]), 32'd0);
      check($sformatf("%s/s%0d pass", tag, st[i]),      32'(pass_w[i]), 32'd0);
      check($sformatf("%s/s%0d err_count", tag, st[i]), 32'(err_w[i]),  32'd0);
      check($sformatf("%s/s%0d fail_vec", tag, st[i]),  32'(fail_w[i]), 32'd0);
    end
  endtask

  // Table: gate function, registered flag, then per-instance expectations packed
  // as [inst2 | inst1 | inst0] with instances at SETTLE 2, 0, 1.
  typedef struct packed {
    logic [3:0]  g;
    logic        regm;
    logic [11:0] ef;
    logic [8:0]  ee;
    logic [2:0]  ep;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [3:0] mf;
    int         me;
    logic       mp;
    int         pd;
    int         dsum;

    tbl[0] = {4'b1001, 1'b0, {3{4'b0000}}, {3{3'd0}}, 3'b111};  // ideal XNOR
    tbl[1] = {4'b0110, 1'b0, {3{4'b1111}}, {3{3'd4}}, 3'b000};  // XOR substituted
    tbl[2] = {4'b0000, 1'b0, {3{4'b1001}}, {3{3'd2}}, 3'b000};  // stuck at 0
    tbl[3] = {4'b1111, 1'b0, {3{4'b0110}}, {3{3'd2}}, 3'b000};  // stuck at 1
    tbl[4] = {4'b1001, 1'b1, {4'b0000, 4'b1010, 4'b0000}, {3'd0, 3'd2, 3'd0}, 3'b101};
    tbl[5] = {4'b1000, 1'b0, {3{4'b0001}}, {3{3'd1}}, 3'b000};  // AND
    tbl[6] = {4'b0110, 1'b1, {4'b1111, 4'b0101, 4'b1111}, {3'd4, 3'd2, 3'd4}, 3'b000};

    rst      = 1'b1;
    start    = 1'b0;
    g_fn     = 4'b1001;
    reg_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      g_fn     = tbl[k].g;
      reg_mode = tbl[k].regm;
      do_run(20);
      for (int i = 0; i < 3; i++)
        check_run($sformatf("tbl%0d", k), i, tbl[k].ef[4*i +: 4],
                  int'(tbl[k].ee[3*i +: 3]), tbl[k].ep[i]);
    end

    // Stimulus order: each vector held SETTLE+1 cycles, inputs back to 00 in DONE.
    g_fn     = 4'b1001;
    reg_mode = 1'b0;
    do_run(20);
    for (int i = 0; i < 3; i++) begin
      pd = 4 * (st[i] + 1);
      for (int c = 0; c <= pd; c++)
        check($sformatf("ab_seq/s%0d c%0d", st[i], c), 32'(ab_log[i][c]),
              (c < pd) ? 32'(c / (st[i] + 1)) : 32'd0);
    end

    // start held high: no restart mid-run, one done, new run on the first IDLE edge.
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      for (int i = 0; i < 3; i++) begin
        busy_log[i][c] = busy_w[i];
        done_log[i][c] = done_w[i];
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pd   = 4 * (st[i] + 1);
      dsum = 0;
      for (int c = 0; c <= pd + 1; c++) dsum += int'(done_log[i][c]);
      check($sformatf("hold/s%0d done_pulses", st[i]), 32'(dsum), 32'd1);
      check($sformatf("hold/s%0d done_at_end", st[i]), 32'(done_log[i][pd]), 32'd1);
      check($sformatf("hold/s%0d busy_last", st[i]), 32'(busy_log[i][pd-1]), 32'd1);
      check($sformatf("hold/s%0d busy_idle", st[i]), 32'(busy_log[i][pd+1]), 32'd0);
      check($sformatf("hold/s%0d restart", st[i]), 32'(busy_log[i][pd+2]), 32'd1);
    end
    repeat (30) @(negedge clk);

    // Reset in the middle of vector 2 of the SETTLE=2 instance.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst/s2 a_out idx2", 32'(a_w[0]), 32'd1);
    check("midrst/s2 b_out idx2", 32'(b_w[0]), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst  = 1'b0;
    dsum = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_w[0] || done_w[1] || done_w[2]) dsum++;
      @(negedge clk);
    end
    check("midrst no_done", 32'(dsum), 32'd0);
    do_run(20);
    for (int i = 0; i < 3; i++) check_run("after_rst", i, 4'b0000, 0, 1'b1);

    // Random gate functions against the reference model.
    for (int r = 0; r < 24; r++) begin
      g_fn     = 4'($urandom_range(0, 15));
      reg_mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_run(20);
      for (int i = 0; i < 3; i++) begin
        model(g_fn, reg_mode, st[i], mf, me, mp);
        check_run($sformatf("rnd%0d g%h r%0d", r, g_fn, reg_mode), i, mf, me, mp);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
